// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the register file with scoreboard.
package reg_file_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on issue, cleared on
// writeback, flushed in bulk; lookups hide a bit retiring this cycle.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic          flush,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREGS-1:0] pending;

    // Busy unless a writeback to this address retires it now without a racing issue.
    function automatic logic lookup(input logic [AW-1:0] a);
        logic retiring;
        retiring = clr_en && (clr_addr == a) && !(set_en && (set_addr == a));
        return pending[a] && !retiring;
    endfunction

    // Pending-bit update; the set is applied last so issue beats writeback.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            if (clr_en) pending[clr_addr] <= 1'b0;
            if (set_en) pending[set_addr] <= 1'b1;
        end
    end

    // Combinational lookups for both source operands.
    always_comb begin
        busy1 = lookup(addr1);
        busy2 = lookup(addr2);
    end

endmodule

// File: rtl/reg_file_scb.sv
// Two-read, one-write register file with same-cycle bypass, a pending-bit
// scoreboard and a bulk-clear sequencer that zeros one register per cycle.
module reg_file_scb
    import reg_file_pkg::*;
#(
    parameter int  XLEN  = DEFAULT_XLEN,
    parameter int  NREGS = DEFAULT_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            WR_EN,
    input  logic [AW-1:0]   WR_ADDR,
    input  logic [XLEN-1:0] WR_DATA,
    input  logic [AW-1:0]   ADDR1,
    input  logic [AW-1:0]   ADDR2,
    output logic [XLEN-1:0] RS1,
    output logic [XLEN-1:0] RS2,
    input  logic            ISSUE_EN,
    input  logic [AW-1:0]   ISSUE_ADDR,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic            CLR,
    output logic            CLR_BUSY
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [XLEN-1:0] regs [NREGS];
    rf_state_t       state;
    logic [AW-1:0]   clr_idx;
    logic            clr_busy_q;
    logic            idle;
    logic            wr_commit;
    logic            issue_ok;
    logic            start_clear;
    logic            sb_busy1;
    logic            sb_busy2;

    // x0 is never a write or issue target; nothing is accepted outside IDLE.
    assign idle        = (state == IDLE);
    assign wr_commit   = idle && WR_EN && (WR_ADDR != '0);
    assign issue_ok    = idle && ISSUE_EN && (ISSUE_ADDR != '0);
    assign start_clear = idle && CLR;
    assign CLR_BUSY    = clr_busy_q;

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .CLK      (CLK),
        .RST      (RST),
        .set_en   (issue_ok),
        .set_addr (ISSUE_ADDR),
        .clr_en   (wr_commit),
        .clr_addr (WR_ADDR),
        .flush    (start_clear),
        .addr1    (ADDR1),
        .addr2    (ADDR2),
        .busy1    (sb_busy1),
        .busy2    (sb_busy2)
    );

    // Clear sequencer: walk index 1..NREGS-1, CLR_BUSY registered alongside the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            clr_idx    <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLR) begin
                        state      <= CLEAR;
                        clr_idx    <= AW'(1);
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state      <= IDLE;
                        clr_idx    <= '0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    clr_idx    <= '0;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Data array: the clear sweep owns the write port while CLEAR is active.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[clr_idx] <= '0;
        end else if (wr_commit) begin
            regs[WR_ADDR] <= WR_DATA;
        end
    end

    // Read ports with writeback bypass; everything reads as idle/zero during a clear.
    always_comb begin
        RS1   = '0;
        RS2   = '0;
        BUSY1 = 1'b0;
        BUSY2 = 1'b0;
        if (idle) begin
            if (ADDR1 != '0) begin
                RS1 = (wr_commit && (WR_ADDR == ADDR1)) ? WR_DATA : regs[ADDR1];
            end
            if (ADDR2 != '0) begin
                RS2 = (wr_commit && (WR_ADDR == ADDR2)) ? WR_DATA : regs[ADDR2];
            end
            BUSY1 = sb_busy1;
            BUSY2 = sb_busy2;
        end
    end

endmodule

// File: tb/tb_reg_file_scb.sv
// Testbench for reg_file_scb: directed scenarios plus randomized traffic
// compared against a behavioural model of the register file and scoreboard.
module tb_reg_file_scb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            CLK = 1'b0;
    logic            RST;
    logic            WR_EN;
    logic [AW-1:0]   WR_ADDR;
    logic [XLEN-1:0] WR_DATA;
    logic [AW-1:0]   ADDR1;
    logic [AW-1:0]   ADDR2;
    logic [XLEN-1:0] RS1;
    logic [XLEN-1:0] RS2;
    logic            ISSUE_EN;
    logic [AW-1:0]   ISSUE_ADDR;
    logic            BUSY1;
    logic            BUSY2;
    logic            CLR;
    logic            CLR_BUSY;

    int checks = 0;
    int errors = 0;

    // Behavioural model: architectural contents, pending set, clear countdown.
    logic [XLEN-1:0] m_regs [NREGS];
    bit [NREGS-1:0]  m_pend;
    bit              m_clearing;
    int              m_left;

    reg_file_scb #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .ADDR1      (ADDR1),
        .ADDR2      (ADDR2),
        .RS1        (RS1),
        .RS2        (RS2),
        .ISSUE_EN   (ISSUE_EN),
        .ISSUE_ADDR (ISSUE_ADDR),
        .BUSY1      (BUSY1),
        .BUSY2      (BUSY2),
        .CLR        (CLR),
        .CLR_BUSY   (CLR_BUSY)
    );

    // Free-running clock, 10 time units per period.
    always #5 CLK = ~CLK;

    function automatic bit m_commit();
        return !m_clearing && WR_EN && (WR_ADDR != 0);
    endfunction

    function automatic bit m_issue();
        return !m_clearing && ISSUE_EN && (ISSUE_ADDR != 0);
    endfunction

    function automatic logic [XLEN-1:0] exp_rs(input logic [AW-1:0] a);
        if (m_clearing || a == 0) return '0;
        if (m_commit() && WR_ADDR == a) return WR_DATA;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (m_clearing) return 1'b0;
        if (m_commit() && WR_ADDR == a && !(m_issue() && ISSUE_ADDR == a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_pend     = '0;
        m_clearing = 1'b0;
        m_left     = 0;
    endtask

    task automatic idle_inputs();
        WR_EN      = 1'b0;
        WR_ADDR    = '0;
        WR_DATA    = '0;
        ADDR1      = '0;
        ADDR2      = '0;
        ISSUE_EN   = 1'b0;
        ISSUE_ADDR = '0;
        CLR        = 1'b0;
    endtask

    // Advance one clock edge and apply that edge's effect to the model.
    task automatic cycle();
        bit              c;
        bit              is;
        bit              cl;
        logic [AW-1:0]   wa;
        logic [AW-1:0]   ia;
        logic [XLEN-1:0] wd;
        c  = m_commit();
        is = m_issue();
        cl = !m_clearing && CLR;
        wa = WR_ADDR;
        ia = ISSUE_ADDR;
        wd = WR_DATA;
        @(posedge CLK);
        if (m_clearing) begin
            m_left--;
            if (m_left == 0) m_clearing = 1'b0;
        end else begin
            if (c) m_regs[wa] = wd;
            if (cl) begin
                m_pend = '0;
                for (int i = 1; i < NREGS; i++) m_regs[i] = '0;
                m_clearing = 1'b1;
                m_left     = NREGS - 1;
            end else begin
                if (c)  m_pend[wa] = 1'b0;
                if (is) m_pend[ia] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        ADDR1 = 5'd3;
        ADDR2 = 5'd17;
        RST   = 1'b1;
        m_reset();
        #3;
        checks++;
        if (RS1 !== 32'h0 || RS2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rs: RS1=%h RS2=%h expected 0", RS1, RS2);
        end
        checks++;
        if (BUSY1 !== 1'b0 || BUSY2 !== 1'b0 || CLR_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: BUSY1=%b BUSY2=%b CLR_BUSY=%b expected 0", BUSY1, BUSY2, CLR_BUSY);
        end
        @(negedge CLK);
        RST = 1'b0;
        cycle();
    endtask

    task automatic test_write_bypass();
        idle_inputs();
        WR_EN   = 1'b1;
        WR_ADDR = 5'd5;
        WR_DATA = 32'hDEADBEEF;
        ADDR2   = 5'd5;
        #1;
        checks++;
        if (RS2 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL bypass_rs2: got %h expected deadbeef", RS2);
        end
        cycle();
        idle_inputs();
        ADDR1 = 5'd5;
        #1;
        checks++;
        if (RS1 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL write_read_rs1: got %h expected deadbeef", RS1);
        end
    endtask

    task automatic test_x0();
        idle_inputs();
        WR_EN      = 1'b1;
        WR_ADDR    = '0;
        WR_DATA    = 32'hFFFFFFFF;
        ISSUE_EN   = 1'b1;
        ISSUE_ADDR = '0;
        ADDR1      = '0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                WR_EN    = 1'b0;
                ISSUE_EN = 1'b0;
            end
            #1;
            checks++;
            if (RS1 !== 32'h0 || BUSY1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL x0_read step %0d: RS1=%h BUSY1=%b expected 0/0", k, RS1, BUSY1);
            end
            cycle();
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        ISSUE_EN   = 1'b1;
        ISSUE_ADDR = 5'd7;
        cycle();
        ISSUE_EN = 1'b0;
        ADDR1    = 5'd7;
        #1;
        checks++;
        if (BUSY1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL issue_busy: BUSY1=%b expected 1", BUSY1);
        end
        WR_EN   = 1'b1;
        WR_ADDR = 5'd7;
        WR_DATA = 32'h12;
        #1;
        checks++;
        if (BUSY1 !== 1'b0 || RS1 !== 32'h12) begin
            errors++;
            $display("[TB] FAIL write_unbusy: BUSY1=%b RS1=%h expected 0/00000012", BUSY1, RS1);
        end
        cycle();
        WR_EN = 1'b0;
        #1;
        checks++;
        if (BUSY1 !== 1'b0 || RS1 !== 32'h12) begin
            errors++;
            $display("[TB] FAIL after_write: BUSY1=%b RS1=%h expected 0/00000012", BUSY1, RS1);
        end
        WR_EN      = 1'b1;
        WR_DATA    = 32'h34;
        ISSUE_EN   = 1'b1;
        ISSUE_ADDR = 5'd7;
        cycle();
        WR_EN    = 1'b0;
        ISSUE_EN = 1'b0;
        #1;
        checks++;
        if (BUSY1 !== 1'b1 || RS1 !== 32'h34) begin
            errors++;
            $display("[TB] FAIL issue_wins: BUSY1=%b RS1=%h expected 1/00000034", BUSY1, RS1);
        end
    endtask

    task automatic test_clear();
        int cnt;
        idle_inputs();
        for (int i = 1; i < NREGS; i++) begin
            WR_EN   = 1'b1;
            WR_ADDR = AW'(i);
            WR_DATA = XLEN'(i);
            cycle();
        end
        idle_inputs();
        ISSUE_EN   = 1'b1;
        ISSUE_ADDR = 5'd6;
        cycle();
        idle_inputs();
        ADDR1 = 5'd17;
        ADDR2 = 5'd6;
        #1;
        checks++;
        if (RS1 !== 32'd17 || BUSY2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fill: RS1=%h BUSY2=%b expected 00000011/1", RS1, BUSY2);
        end
        CLR = 1'b1;
        cycle();
        CLR = 1'b0;
        cnt = 0;
        while (CLR_BUSY === 1'b1 && cnt < 100) begin
            WR_EN   = (cnt == 5);
            WR_ADDR = 5'd3;
            WR_DATA = 32'h55;
            ADDR2   = 5'd3;
            #1;
            checks++;
            if (RS2 !== 32'h0 || BUSY2 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clear_forced cycle %0d: RS2=%h BUSY2=%b expected 0/0", cnt, RS2, BUSY2);
            end
            cycle();
            cnt++;
        end
        checks++;
        if (cnt != NREGS - 1) begin
            errors++;
            $display("[TB] FAIL clear_length: CLR_BUSY high %0d cycles expected %0d", cnt, NREGS - 1);
        end
        idle_inputs();
        for (int i = 0; i < NREGS; i++) begin
            ADDR1 = AW'(i);
            ADDR2 = AW'(i);
            #1;
            checks++;
            if (RS1 !== 32'h0 || BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL after_clear x%0d: RS1=%h BUSY1=%b BUSY2=%b expected 0", i, RS1, BUSY1, BUSY2);
            end
        end
        cycle();
    endtask

    task automatic test_reset_mid_clear();
        idle_inputs();
        WR_EN   = 1'b1;
        WR_ADDR = 5'd20;
        WR_DATA = 32'hAA;
        cycle();
        idle_inputs();
        ISSUE_EN   = 1'b1;
        ISSUE_ADDR = 5'd9;
        cycle();
        idle_inputs();
        CLR = 1'b1;
        cycle();
        CLR = 1'b0;
        repeat (9) cycle();
        ADDR1 = 5'd20;
        ADDR2 = 5'd9;
        #2;
        RST = 1'b1;
        m_reset();
        #1;
        checks++;
        if (CLR_BUSY !== 1'b0 || RS1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: CLR_BUSY=%b RS1=%h expected 0/0", CLR_BUSY, RS1);
        end
        @(negedge CLK);
        RST = 1'b0;
        ADDR1 = 5'd9;
        #1;
        checks++;
        if (BUSY1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pending: BUSY1=%b expected 0", BUSY1);
        end
        WR_EN   = 1'b1;
        WR_ADDR = 5'd4;
        WR_DATA = 32'h99;
        cycle();
        idle_inputs();
        ADDR1 = 5'd4;
        #1;
        checks++;
        if (RS1 !== 32'h99 || CLR_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_edge: RS1=%h CLR_BUSY=%b expected 00000099/0", RS1, CLR_BUSY);
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        logic            b1;
        logic            b2;
        for (int n = 0; n < 400; n++) begin
            WR_EN      = ($urandom_range(0, 2) == 0);
            WR_ADDR    = AW'($urandom_range(0, 7));
            WR_DATA    = $urandom;
            ADDR1      = AW'($urandom_range(0, 7));
            ADDR2      = AW'($urandom_range(0, 7));
            ISSUE_EN   = ($urandom_range(0, 3) == 0);
            ISSUE_ADDR = AW'($urandom_range(0, 7));
            CLR        = ($urandom_range(0, 79) == 0);
            #1;
            e1 = exp_rs(ADDR1);
            e2 = exp_rs(ADDR2);
            b1 = exp_busy(ADDR1);
            b2 = exp_busy(ADDR2);
            checks++;
            if (RS1 !== e1 || RS2 !== e2) begin
                errors++;
                $display("[TB] FAIL rand_rs iter %0d: RS1=%h RS2=%h expected %h %h", n, RS1, RS2, e1, e2);
            end
            checks++;
            if (BUSY1 !== b1 || BUSY2 !== b2) begin
                errors++;
                $display("[TB] FAIL rand_busy iter %0d: BUSY1=%b BUSY2=%b expected %b %b", n, BUSY1, BUSY2, b1, b2);
            end
            checks++;
            if (CLR_BUSY !== m_clearing) begin
                errors++;
                $display("[TB] FAIL rand_clr_busy iter %0d: CLR_BUSY=%b expected %b", n, CLR_BUSY, m_clearing);
            end
            cycle();
        end
        idle_inputs();
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_write_bypass();
        test_x0();
        test_scoreboard();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
